mic_microsequencer: RTL
=======================

// Module: mic_microsequencer
// PURPOSE
//  Microprogram sequencer for the Mic datapath. Owns MPC (the control store address).
//  Each cycle it computes the next MPC from the MIR NEXT_ADDRESS/JAM fields, the
//  ALU N/Z flags and MBR. Issues memory strobes and stalls the datapath until memory
//  acknowledges. Sits between the control store/MIR and the ALU/register datapath.
// PARAMETERS
//  ADDR_W     9      control store address width; must equal MBR_W+1
//  MBR_W      8      MBR width, ORed into MPC low bits on JMPC
//  RESET_ADDR 9'h000 MPC value loaded on reset
//  HALT_ADDR  9'h1FF MPC value that stops sequencing
// PORTS
//  clk           in  1       clock, rising edge
//  rst_n         in  1       asynchronous, active-low reset
//  mir_next_addr in  ADDR_W  NEXT_ADDRESS field of current microinstruction
//  mir_jam       in  3       {JMPC, JAMN, JAMZ}
//  mir_mem       in  3       {WRITE, READ, FETCH}
//  alu_n         in  1       ALU result negative, current cycle
//  alu_z         in  1       ALU result zero, current cycle
//  mbr           in  MBR_W   memory byte register contents
//  mem_ack       in  1       memory operation complete (1-cycle pulse)
//  mpc           out ADDR_W  registered control store address
//  mir_load      out 1       1 = datapath/MIR commit enabled this cycle
//  mem_wr        out 1       write strobe, 1-cycle pulse
//  mem_rd        out 1       read strobe, 1-cycle pulse
//  mem_fetch     out 1       fetch strobe, 1-cycle pulse
//  n_flag        out 1       registered N of last committed microinstruction
//  z_flag        out 1       registered Z of last committed microinstruction
//  halted        out 1       1 in HALT state
// BEHAVIOUR
//  Reset (async, rst_n=0): mpc=RESET_ADDR; state=RUN; mem_* =0; n_flag=z_flag=0.
//    Reset mid-WAIT_MEM abandons the pending access. No strobe is re-issued.
//  FSM states RUN, WAIT_MEM, HALT. mir_load=1 only in RUN (decoded from state reg).
//    halted=1 only in HALT.
//  Next-address (combinational, RUN only):
//    hi  = mir_next_addr[ADDR_W-1] | (JAMN & alu_n) | (JAMZ & alu_z)
//    lo  = JMPC ? (mir_next_addr[MBR_W-1:0] | mbr) : mir_next_addr[MBR_W-1:0]
//    nxt = {hi, lo}. No carry or wrap arithmetic; pure OR.
//  RUN, each edge:
//    mpc<=nxt; n_flag<=alu_n; z_flag<=alu_z.
//    If nxt==HALT_ADDR -> HALT, and no strobes are issued.
//    Else if mir_mem!=0: mem_{wr,rd,fetch}<=mir_mem bits (any combination legal);
//      state->WAIT_MEM.
//    Else stay in RUN.
//  WAIT_MEM:
//    Strobes are high exactly on the first WAIT_MEM cycle, then 0.
//    mpc, n_flag and z_flag hold. mir_load=0.
//    mem_ack=1 -> RUN on next edge. This includes an ack in the same cycle as the strobes.
//    Minimum stall is 1 cycle.
//  mem_ack in RUN or HALT: ignored.
//  HALT: all outputs hold, strobes 0. Exit only via reset.
//  Latency: MPC update 1 cycle after inputs; memory microinstruction costs 1+N cycles,
//    where N = cycles until ack.
// TESTING
//  1 rst_n=0 during WAIT_MEM -> mpc=0x000, mem_*=0, mir_load=1 immediately after release.
//  2 next_addr=0x012, jam=000, mem=000 -> mpc=0x012 after 1 edge, mir_load stays 1.
//  3 next_addr=0x092, jam=001: alu_z=1 -> mpc=0x192; alu_z=0 -> mpc=0x092.
//    Repeat with JAMN/alu_n.
//  4 next_addr=0x000, jam=100, mbr=0x60 -> mpc=0x060.
//    next_addr=0x105, mbr=0x0A -> mpc=0x10F.
//  5 mem=010, mem_ack 3 cycles after strobe -> mem_rd high 1 cycle, mir_load low 3 cycles,
//    mpc stable. Repeat with mem=101 and with ack coincident with the strobe (1-cycle stall).
//  6 next_addr=0x1FF -> halted=1, mir_load=0; further inputs and mem_ack leave mpc=0x1FF;
//    reset recovers.

Source files
------------

// File: rtl/mic_microsequencer.sv
// Microprogram sequencer for the Mic datapath.
// Owns MPC, forms the next control store address from NEXT_ADDRESS/JAM, the
// ALU flags and MBR, issues one-cycle memory strobes and stalls the datapath
// (mir_load low) until memory acknowledges. HALT_ADDR parks the sequencer
// until reset.
module mic_microsequencer #(
    parameter int                ADDR_W     = 9,
    parameter int                MBR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mir_next_addr,
    input  logic [2:0]        mir_jam,
    input  logic [2:0]        mir_mem,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic [MBR_W-1:0]  mbr,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mpc,
    output logic              mir_load,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic              mem_fetch,
    output logic              n_flag,
    output logic              z_flag,
    output logic              halted
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StWaitMem = 2'd1,
        StHalt    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] mpc_q;
    logic              n_q;
    logic              z_q;
    logic              memWr_q;
    logic              memRd_q;
    logic              memFetch_q;

    // JAM field decode: bit 2 = JMPC, bit 1 = JAMN, bit 0 = JAMZ
    logic              jmpc;
    logic              jamN;
    logic              jamZ;
    logic              nextHi;
    logic [MBR_W-1:0]  nextLo;
    logic [ADDR_W-1:0] nextAddr;
    logic              goHalt;
    logic              memReq;

    assign jmpc = mir_jam[2];
    assign jamN = mir_jam[1];
    assign jamZ = mir_jam[0];

    // Next address is a pure OR of the fields; no carries ever propagate
    always_comb begin
        nextHi   = mir_next_addr[ADDR_W-1] | (jamN & alu_n) | (jamZ & alu_z);
        nextLo   = jmpc ? (mir_next_addr[MBR_W-1:0] | mbr)
                        : mir_next_addr[MBR_W-1:0];
        nextAddr = {nextHi, nextLo};
        goHalt   = (nextAddr == HALT_ADDR);
        memReq   = (mir_mem != 3'b000);
    end

    // State register; reset abandons any pending memory access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halting takes priority over starting a memory cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (goHalt) begin
                    state_d = StHalt;
                end else if (memReq) begin
                    state_d = StWaitMem;
                end
            end
            StWaitMem: begin
                if (mem_ack) begin
                    state_d = StRun;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // MPC, flags and strobes commit only in RUN; strobes self-clear after one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpc_q      <= RESET_ADDR;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            memWr_q    <= 1'b0;
            memRd_q    <= 1'b0;
            memFetch_q <= 1'b0;
        end else begin
            memWr_q    <= 1'b0;
            memRd_q    <= 1'b0;
            memFetch_q <= 1'b0;
            if (state_q == StRun) begin
                mpc_q <= nextAddr;
                n_q   <= alu_n;
                z_q   <= alu_z;
                if (!goHalt && memReq) begin
                    memWr_q    <= mir_mem[2];
                    memRd_q    <= mir_mem[1];
                    memFetch_q <= mir_mem[0];
                end
            end
        end
    end

    // Outputs decoded from the state register and datapath registers
    always_comb begin
        mir_load  = (state_q == StRun);
        halted    = (state_q == StHalt);
        mpc       = mpc_q;
        n_flag    = n_q;
        z_flag    = z_q;
        mem_wr    = memWr_q;
        mem_rd    = memRd_q;
        mem_fetch = memFetch_q;
    end

endmodule
